// File: rtl/acumulador_ventana_pkg.sv
// Shared definitions for the windowed accumulator: FSM state encodings and mode codes.
package acumulador_ventana_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StOut  = 2'd2
    } state_e;

    localparam logic ModeWrap = 1'b0;
    localparam logic ModeSat  = 1'b1;

endpackage

// File: rtl/acumulador_ventana_if.sv
// Sample-in / result-out stream bundle of the windowed accumulator.
interface acumulador_ventana_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ACC_W  = 6
) ();

    logic              i_valid;
    logic [DATA_W-1:0] i_entrada;
    logic              o_ready;
    logic              o_valid;
    logic              i_ready;
    logic [ACC_W-1:0]  o_data;
    logic              o_overflow;

    // master: sample source plus result consumer; slave: the accumulator
    modport master (
        output i_valid, i_entrada, i_ready,
        input  o_ready, o_valid, o_data, o_overflow
    );

    modport slave (
        input  i_valid, i_entrada, i_ready,
        output o_ready, o_valid, o_data, o_overflow
    );

endinterface

// File: rtl/acumulador_ventana_sumador.sv
// Combinational ACC_W adder with carry out and wrap/saturate result select.
module acumulador_ventana_sumador
    import acumulador_ventana_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ACC_W  = 6
) (
    input  logic [ACC_W-1:0]  sum,
    input  logic [DATA_W-1:0] sample,
    input  logic              sat,
    output logic [ACC_W-1:0]  result,
    output logic              carry
);

    logic [ACC_W:0] total;

    always_comb begin
        total = {1'b0, sum} + {{(ACC_W + 1 - DATA_W){1'b0}}, sample};
        carry = total[ACC_W];
        if (carry && (sat == ModeSat)) begin
            result = '1;
        end else begin
            result = total[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/acumulador_ventana.sv
// Windowed accumulator: sums i_len stream samples, then holds the sum until the consumer takes it.
module acumulador_ventana
    import acumulador_ventana_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ACC_W  = 6,
    parameter int unsigned LEN_W  = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_sat,
    acumulador_ventana_if.slave bus,
    output logic             o_busy
);

    state_e           state_q;
    logic [ACC_W-1:0] sum_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] len_q;
    logic             sat_q;
    logic             ovf_q;

    logic [ACC_W-1:0] add_res;
    logic             add_carry;
    logic [LEN_W-1:0] count_nxt;
    logic             accept;

    acumulador_ventana_sumador #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sumador (
        .sum    (sum_q),
        .sample (bus.i_entrada),
        .sat    (sat_q),
        .result (add_res),
        .carry  (add_carry)
    );

    always_comb begin
        count_nxt = count_q + LEN_W'(1);
        accept    = bus.i_valid && bus.o_ready;
    end

    assign bus.o_overflow = ovf_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            sum_q       <= '0;
            count_q     <= '0;
            len_q       <= '0;
            sat_q       <= ModeWrap;
            ovf_q       <= 1'b0;
            bus.o_ready <= 1'b0;
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            o_busy      <= 1'b0;
        end else if (i_clear) begin
            state_q     <= StIdle;
            sum_q       <= '0;
            count_q     <= '0;
            len_q       <= '0;
            sat_q       <= ModeWrap;
            ovf_q       <= 1'b0;
            bus.o_ready <= 1'b0;
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            o_busy      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start && (i_len != '0)) begin
                        len_q       <= i_len;
                        sat_q       <= i_sat;
                        sum_q       <= '0;
                        count_q     <= '0;
                        ovf_q       <= 1'b0;
                        bus.o_ready <= 1'b1;
                        o_busy      <= 1'b1;
                        state_q     <= StAcc;
                    end
                end
                StAcc: begin
                    if (accept) begin
                        sum_q   <= add_res;
                        ovf_q   <= ovf_q | add_carry;
                        count_q <= count_nxt;
                        // Last sample: result and flag are presented from the next cycle on
                        if (count_nxt == len_q) begin
                            state_q     <= StOut;
                            bus.o_ready <= 1'b0;
                            bus.o_valid <= 1'b1;
                            bus.o_data  <= add_res;
                        end
                    end
                end
                StOut: begin
                    if (bus.i_ready && bus.o_valid) begin
                        state_q     <= StIdle;
                        bus.o_valid <= 1'b0;
                        bus.o_data  <= '0;
                        o_busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    bus.o_ready <= 1'b0;
                    bus.o_valid <= 1'b0;
                    bus.o_data  <= '0;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acumulador_ventana.sv
// Directed self-checking bench for acumulador_ventana with hand-computed expected values.
module tb_acumulador_ventana;

    logic       clk;
    logic       i_rst_n;
    logic       i_clear;
    logic       i_start;
    logic [3:0] i_len;
    logic       i_sat;
    logic       o_busy;

    int unsigned n_checks;
    int unsigned n_fail;

    acumulador_ventana_if #(.DATA_W(4), .ACC_W(6)) bus ();

    acumulador_ventana #(
        .DATA_W (4),
        .ACC_W  (6),
        .LEN_W  (4)
    ) dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_clear),
        .i_start (i_start),
        .i_len   (i_len),
        .i_sat   (i_sat),
        .bus     (bus.slave),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window(input logic [3:0] len, input logic sat);
        i_start = 1'b1;
        i_len   = len;
        i_sat   = sat;
        step();
        i_start = 1'b0;
    endtask

    task automatic feed(input logic [3:0] s);
        bus.i_valid   = 1'b1;
        bus.i_entrada = s;
        step();
        bus.i_valid   = 1'b0;
    endtask

    task automatic take_result();
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        i_rst_n       = 1'b0;
        i_clear       = 1'b0;
        i_start       = 1'b0;
        i_len         = 4'd0;
        i_sat         = 1'b0;
        bus.i_valid   = 1'b0;
        bus.i_entrada = 4'd0;
        bus.i_ready   = 1'b0;
        #12;
        check_eq("reset_valid", {31'd0, bus.o_valid}, 32'd0);
        check_eq("reset_ready", {31'd0, bus.o_ready}, 32'd0);
        check_eq("reset_data", {26'd0, bus.o_data}, 32'd0);
        check_eq("reset_busy", {31'd0, o_busy}, 32'd0);
        i_rst_n = 1'b1;
        step();

        // Basic window: 5+7+9
        start_window(4'd3, 1'b0);
        check_eq("basic_busy", {31'd0, o_busy}, 32'd1);
        check_eq("basic_ready", {31'd0, bus.o_ready}, 32'd1);
        feed(4'd5);
        feed(4'd7);
        check_eq("basic_not_yet", {31'd0, bus.o_valid}, 32'd0);
        feed(4'd9);
        check_eq("basic_valid", {31'd0, bus.o_valid}, 32'd1);
        check_eq("basic_data", {26'd0, bus.o_data}, 32'd21);
        check_eq("basic_ovf", {31'd0, bus.o_overflow}, 32'd0);
        check_eq("basic_ready_out", {31'd0, bus.o_ready}, 32'd0);
        take_result();
        check_eq("basic_done_valid", {31'd0, bus.o_valid}, 32'd0);
        check_eq("basic_done_data", {26'd0, bus.o_data}, 32'd0);
        check_eq("basic_done_busy", {31'd0, o_busy}, 32'd0);

        // Wrap: 6*15 = 90 -> 26
        start_window(4'd6, 1'b0);
        for (int k = 0; k < 6; k++) feed(4'd15);
        check_eq("wrap_valid", {31'd0, bus.o_valid}, 32'd1);
        check_eq("wrap_data", {26'd0, bus.o_data}, 32'd26);
        check_eq("wrap_ovf", {31'd0, bus.o_overflow}, 32'd1);
        take_result();

        // Saturate: clamps at 63 and stays there
        start_window(4'd6, 1'b1);
        check_eq("sat_ovf_cleared", {31'd0, bus.o_overflow}, 32'd0);
        for (int k = 0; k < 6; k++) feed(4'd15);
        check_eq("sat_valid", {31'd0, bus.o_valid}, 32'd1);
        check_eq("sat_data", {26'd0, bus.o_data}, 32'd63);
        check_eq("sat_ovf", {31'd0, bus.o_overflow}, 32'd1);
        take_result();

        // Back-pressure with an input gap
        start_window(4'd2, 1'b0);
        feed(4'd3);
        step();
        check_eq("gap_no_valid", {31'd0, bus.o_valid}, 32'd0);
        feed(4'd4);
        for (int k = 0; k < 4; k++) begin
            i_start = 1'b1;
            i_len   = 4'd5;
            step();
            check_eq("bp_valid", {31'd0, bus.o_valid}, 32'd1);
            check_eq("bp_data", {26'd0, bus.o_data}, 32'd7);
            check_eq("bp_ready", {31'd0, bus.o_ready}, 32'd0);
        end
        i_start = 1'b0;
        check_eq("bp_ovf", {31'd0, bus.o_overflow}, 32'd0);
        take_result();
        check_eq("bp_idle", {31'd0, o_busy}, 32'd0);
        check_eq("bp_valid_drop", {31'd0, bus.o_valid}, 32'd0);

        // Clear with a valid sample in ACC drops it
        start_window(4'd4, 1'b0);
        feed(4'd1);
        i_clear       = 1'b1;
        bus.i_valid   = 1'b1;
        bus.i_entrada = 4'd9;
        step();
        i_clear     = 1'b0;
        bus.i_valid = 1'b0;
        check_eq("clr_busy", {31'd0, o_busy}, 32'd0);
        check_eq("clr_ready", {31'd0, bus.o_ready}, 32'd0);

        // Zero length start is ignored
        start_window(4'd0, 1'b0);
        check_eq("len0_busy", {31'd0, o_busy}, 32'd0);

        // Clear wins over start
        i_clear = 1'b1;
        start_window(4'd3, 1'b0);
        i_clear = 1'b0;
        check_eq("clr_start_busy", {31'd0, o_busy}, 32'd0);

        // Fresh window after the aborted one starts from zero
        start_window(4'd1, 1'b0);
        feed(4'd2);
        check_eq("fresh_data", {26'd0, bus.o_data}, 32'd2);
        take_result();

        // Async reset mid-window
        start_window(4'd5, 1'b0);
        feed(4'd9);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        check_eq("rst_mid_ready", {31'd0, bus.o_ready}, 32'd0);
        check_eq("rst_mid_valid", {31'd0, bus.o_valid}, 32'd0);
        check_eq("rst_mid_data", {26'd0, bus.o_data}, 32'd0);
        check_eq("rst_mid_ovf", {31'd0, bus.o_overflow}, 32'd0);
        step();
        i_rst_n = 1'b1;
        step();
        check_eq("rst_after_busy", {31'd0, o_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
